// File: rtl/morse_msg_sequencer_if.sv
// Letter-push handshake between the switch/key input logic and the Morse sequencer.
interface morse_msg_sequencer_if;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;

    modport master (output in_valid, output in_code, input in_ready);
    modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/morse_msg_sequencer.sv
// Queues Morse letters I..P and plays them on one LED, one symbol bit per tick plus a letter gap.
// Optional MORSE_SEQ_ABORT_EN adds a synchronous abort input that flushes queue and playback.
module morse_msg_sequencer #(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned GAP_TICKS = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
`ifdef MORSE_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    morse_msg_sequencer_if.slave   in_bus,
    output logic                   led,
    output logic                   busy,
    output logic                   letter_done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

    state_e        state_q, state_d;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [12:0]   shreg_q, shreg_d;
    logic [3:0]    bits_q, bits_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          led_q, led_d;
    logic          done_q, done_d;
    logic          ready, push, pop, tick, flush;
    logic [12:0]   pat;
    logic [3:0]    pat_len;

`ifdef MORSE_SEQ_ABORT_EN
    assign flush = abort;
`else
    assign flush = 1'b0;
`endif

    assign ready           = (count_q != CW'(DEPTH));
    assign in_bus.in_ready = ready;
    assign push            = in_bus.in_valid && ready && !flush;
    assign tick            = (tick_cnt_q == TickMax);

    // Patterns are left-aligned so the MSB is always the next symbol to send.
    always_comb begin
        pat     = '0;
        pat_len = '0;
        case (mem_q[rd_ptr_q])
            3'd0:    begin pat = 13'b1010000000000; pat_len = 4'd3;  end
            3'd1:    begin pat = 13'b1011101110111; pat_len = 4'd13; end
            3'd2:    begin pat = 13'b1110101110000; pat_len = 4'd9;  end
            3'd3:    begin pat = 13'b1011101010000; pat_len = 4'd9;  end
            3'd4:    begin pat = 13'b1110111000000; pat_len = 4'd7;  end
            3'd5:    begin pat = 13'b1110100000000; pat_len = 4'd5;  end
            3'd6:    begin pat = 13'b1110111011100; pat_len = 4'd11; end
            default: begin pat = 13'b1011101110100; pat_len = 4'd11; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        done_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;
        shreg_d    = shreg_q;
        bits_d     = bits_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                led_d = 1'b0;
                if (count_q != '0) state_d = StLoad;
            end
            StLoad: begin
                pop        = 1'b1;
                shreg_d    = pat;
                bits_d     = pat_len;
                led_d      = pat[12];
                tick_cnt_d = '0;
                state_d    = StSend;
            end
            StSend: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    if (bits_q == 4'd1) begin
                        led_d   = 1'b0;
                        gap_d   = GW'(GAP_TICKS);
                        state_d = StGap;
                    end else begin
                        shreg_d = shreg_q << 1;
                        led_d   = shreg_q[11];
                        bits_d  = bits_q - 4'd1;
                    end
                end
            end
            StGap: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    gap_d = gap_q - GW'(1);
                    // Decision uses the registered count, so a same-edge push goes via IDLE.
                    if (gap_q == GW'(1)) begin
                        done_d  = 1'b1;
                        state_d = (count_q != '0) ? StLoad : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d    = StIdle;
            led_d      = 1'b0;
            done_d     = 1'b0;
            tick_cnt_d = '0;
            shreg_d    = '0;
            bits_d     = '0;
            gap_d      = '0;
            pop        = 1'b0;
        end

        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tick_cnt_q <= '0;
            shreg_q    <= '0;
            bits_q     <= '0;
            gap_q      <= '0;
            led_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            shreg_q    <= shreg_d;
            bits_q     <= bits_d;
            gap_q      <= gap_d;
            led_q      <= led_d;
            done_q     <= done_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= in_bus.in_code;
    end

    assign led         = led_q;
    assign busy        = (state_q != StIdle);
    assign letter_done = done_q;
    assign fifo_count  = count_q;
endmodule
